// File: rtl/mdu_ctrl_if.sv
// Handshake bundle between the pipeline control and the MDU sequencer.
// The master side drives the issue inputs; the slave (mdu_ctrl) returns strobes and status.
interface mdu_ctrl_if;
   logic       req;
   logic [3:0] op_e;
   logic       use_d;
   logic       div_zero_e;
   logic       start;
   logic       busy;
   logic       commit;
   logic       hi_we;
   logic       lo_we;
   logic       stall_d;
   logic       div0_flag;

   modport master (
      output req, op_e, use_d, div_zero_e,
      input  start, busy, commit, hi_we, lo_we, stall_d, div0_flag
   );

   modport slave (
      input  req, op_e, use_d, div_zero_e,
      output start, busy, commit, hi_we, lo_we, stall_d, div0_flag
   );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU issue/busy/commit sequencer with D-stage stall generation.
// Define MDU_CTRL_DIV0_EN to enable the single-cycle divide-by-zero path and sticky div0_flag.
module mdu_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave io_mdu
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [5:0] MULT_CNT = 6'(MULT_LAT - 1);
   localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

   typedef enum logic {StIdle, StRun} state_t;

   state_t     r_state;
   logic [5:0] r_cnt;
   logic       r_div0;

   logic       w_is_mult;
   logic       w_is_div;
   logic       w_issue_ok;
   logic       w_start;
   logic       w_busy;
   logic       w_commit;
   logic       w_div0_fast;
   logic [5:0] w_load;

   // Reset gates every strobe so a synchronous reset hides any in-flight operation at once.
   always_comb begin
      w_is_mult  = (io_mdu.op_e == OP_MULT) || (io_mdu.op_e == OP_MULTU);
      w_is_div   = (io_mdu.op_e == OP_DIV) || (io_mdu.op_e == OP_DIVU);
      w_issue_ok = !reset && (r_state == StIdle) && !io_mdu.req;
      w_start    = w_issue_ok && (w_is_mult || w_is_div);
      w_busy     = !reset && (r_state == StRun);
      w_commit   = w_busy && (r_cnt == 6'd0);
`ifdef MDU_CTRL_DIV0_EN
      w_div0_fast = w_is_div && io_mdu.div_zero_e;
`else
      w_div0_fast = 1'b0;
`endif
      if (w_div0_fast) begin
         w_load = 6'd0;
      end else if (w_is_mult) begin
         w_load = MULT_CNT;
      end else begin
         w_load = DIV_CNT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_cnt   <= 6'd0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state <= StRun;
                  r_cnt   <= w_load;
               end
            end
            StRun: begin
               if (r_cnt == 6'd0) begin
                  r_state <= StIdle;
               end else begin
                  r_cnt <= r_cnt - 6'd1;
               end
            end
         endcase
      end
   end

`ifdef MDU_CTRL_DIV0_EN
   // Sticky until reset; later normal divides do not clear it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div0 <= 1'b0;
      end else if (w_start && w_div0_fast) begin
         r_div0 <= 1'b1;
      end
   end
`else
   logic w_unused_div_zero;
   assign w_unused_div_zero = io_mdu.div_zero_e;
   assign r_div0 = 1'b0;
`endif

   assign io_mdu.start     = w_start;
   assign io_mdu.busy      = w_busy;
   assign io_mdu.commit    = w_commit;
   assign io_mdu.hi_we     = w_issue_ok && (io_mdu.op_e == OP_MTHI);
   assign io_mdu.lo_we     = w_issue_ok && (io_mdu.op_e == OP_MTLO);
   assign io_mdu.stall_d   = io_mdu.use_d && (w_busy || w_start);
   assign io_mdu.div0_flag = r_div0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: per-cycle expected output vectors queued at drive time,
// popped and checked mid-cycle.
module tb_mdu_ctrl;
   localparam logic [3:0] NONE  = 4'd0;
   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MFHI  = 4'd5;
   localparam logic [3:0] MFLO  = 4'd6;
   localparam logic [3:0] MTHI  = 4'd7;
   localparam logic [3:0] MTLO  = 4'd8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_div0 = 1'b0;
   logic [6:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_ctrl_if bus();

   mdu_ctrl #(
      .MULT_LAT(5),
      .DIV_LAT (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io_mdu(bus)
   );

   // {start, busy, commit, hi_we, lo_we, stall_d, div0_flag}
   function automatic logic [6:0] ev(input bit s, input bit b, input bit c, input bit h,
                                     input bit l, input bit st);
      return {s, b, c, h, l, st, exp_div0};
   endfunction

   task automatic cyc(input logic rst, input logic rq, input logic [3:0] op, input logic ud,
                      input logic dz, input logic [6:0] expv, input string tag);
      logic [6:0] want;
      logic [6:0] got;
      reset          = rst;
      bus.req        = rq;
      bus.op_e       = op;
      bus.use_d      = ud;
      bus.div_zero_e = dz;
      exp_q.push_back(expv);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {bus.start, bus.busy, bus.commit, bus.hi_we, bus.lo_we, bus.stall_d, bus.div0_flag};
      n_checks++;
      assert (got === want)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b (start busy commit hi lo stall div0)",
                tag, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: strobes gated even with a MULT and use_d presented.
      cyc(1, 0, MULT, 1, 0, ev(0, 0, 0, 0, 0, 0), "reset0");
      cyc(1, 0, MTHI, 1, 0, ev(0, 0, 0, 0, 0, 0), "reset1");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "idle");

      // MULT latency: busy 1..5, commit 5 only.
      cyc(0, 0, MULT, 0, 0, ev(1, 0, 0, 0, 0, 0), "mult_start");
      for (int i = 1; i <= 5; i++) cyc(0, 0, NONE, 0, 0, ev(0, 1, i == 5, 0, 0, 0), "mult_run");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "mult_done");

      // req blocks issue and MT* strobes in IDLE.
      cyc(0, 1, MULT, 0, 0, ev(0, 0, 0, 0, 0, 0), "req_mult");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "req_mult_nobusy");
      cyc(0, 1, MTHI, 0, 0, ev(0, 0, 0, 0, 0, 0), "req_mthi");
      cyc(0, 0, MTHI, 0, 0, ev(0, 0, 0, 1, 0, 0), "mthi");

      // MTLO idle, then MTLO in D stalled behind a MULTU.
      cyc(0, 0, MTLO, 0, 0, ev(0, 0, 0, 0, 1, 0), "mtlo");
      cyc(0, 0, MULTU, 1, 0, ev(1, 0, 0, 0, 0, 1), "multu_start_stall");
      for (int i = 1; i <= 5; i++) cyc(0, 0, NONE, 1, 0, ev(0, 1, i == 5, 0, 0, 1), "mtlo_stall");
      cyc(0, 0, NONE, 1, 0, ev(0, 0, 0, 0, 0, 0), "mtlo_unstall");
      cyc(0, 0, MTLO, 0, 0, ev(0, 0, 0, 0, 1, 0), "mtlo_after");

      // DIV with MFLO in D: stall 0..10; MULT in E at commit cannot start.
      cyc(0, 0, DIV, 1, 0, ev(1, 0, 0, 0, 0, 1), "div_start");
      for (int i = 1; i <= 9; i++) cyc(0, 0, NONE, 1, 0, ev(0, 1, 0, 0, 0, 1), "div_run");
      cyc(0, 0, MULT, 1, 0, ev(0, 1, 1, 0, 0, 1), "div_commit_no_start");
      cyc(0, 0, NONE, 1, 0, ev(0, 0, 0, 0, 0, 0), "div_unstall");
      cyc(0, 0, MULT, 0, 0, ev(1, 0, 0, 0, 0, 0), "restart_mult");
      for (int i = 1; i <= 5; i++) cyc(0, 0, NONE, 0, 0, ev(0, 1, i == 5, 0, 0, 0), "restart_run");

      // req and MTHI during RUN do not abort or strobe.
      cyc(0, 0, MULT, 0, 0, ev(1, 0, 0, 0, 0, 0), "req_run_start");
      for (int i = 1; i <= 5; i++) cyc(0, 1, MTHI, 0, 0, ev(0, 1, i == 5, 0, 0, 0), "req_run");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "req_run_done");

      // Reset at cycle 3 of DIVU discards it.
      cyc(0, 0, DIVU, 0, 0, ev(1, 0, 0, 0, 0, 0), "rst_div_start");
      cyc(0, 0, NONE, 0, 0, ev(0, 1, 0, 0, 0, 0), "rst_div_c1");
      cyc(0, 0, NONE, 0, 0, ev(0, 1, 0, 0, 0, 0), "rst_div_c2");
      cyc(1, 0, NONE, 1, 0, ev(0, 0, 0, 0, 0, 0), "rst_div_c3");
      for (int i = 4; i <= 12; i++) cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "rst_div_after");

      // No strobes for MFHI/MFLO/NONE and undefined opcodes.
      cyc(0, 0, MFHI, 0, 0, ev(0, 0, 0, 0, 0, 0), "mfhi");
      cyc(0, 0, MFLO, 0, 0, ev(0, 0, 0, 0, 0, 0), "mflo");
      cyc(0, 0, 4'd12, 0, 0, ev(0, 0, 0, 0, 0, 0), "op12");
      cyc(0, 0, 4'd15, 1, 0, ev(0, 0, 0, 0, 0, 0), "op15");

      // DIVU by zero.
      cyc(0, 0, DIVU, 0, 1, ev(1, 0, 0, 0, 0, 0), "div0_start");
`ifdef MDU_CTRL_DIV0_EN
      exp_div0 = 1'b1;
      cyc(0, 0, NONE, 0, 0, ev(0, 1, 1, 0, 0, 0), "div0_commit");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "div0_idle");
      cyc(0, 0, DIV, 0, 0, ev(1, 0, 0, 0, 0, 0), "div0_normal_start");
      for (int i = 1; i <= 10; i++) cyc(0, 0, NONE, 0, 0, ev(0, 1, i == 10, 0, 0, 0), "div0_normal");
      cyc(1, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "div0_reset");
      exp_div0 = 1'b0;
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "div0_cleared");
`else
      for (int i = 1; i <= 10; i++) cyc(0, 0, NONE, 0, 1, ev(0, 1, i == 10, 0, 0, 0), "divz_run");
      cyc(0, 0, NONE, 0, 0, ev(0, 0, 0, 0, 0, 0), "divz_done");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
